// File: rtl/ps2_receiver_pkg.sv
// Shared definitions for the PS/2 receiver: FSM state encodings, scan-code constants
// and the odd-parity helper.
package ps2_receiver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
    localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;

    // PS/2 frames carry odd parity over the data byte plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// Multi-flop synchroniser for one asynchronous PS/2 pin with a falling-edge detect.
// Flops preset to 1 on reset so an idle-high line never produces a false edge.
module ps2_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic i_pin,
    output logic o_level,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_pin};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_fall  = r_prev & ~r_sync[STAGES-1];

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: deserialises start/8 data/parity/stop frames into byte strobes.
// Optional PS2_BREAK_FILTER_EN hides the F0 break prefix and the released key code after it.
module ps2_receiver
    import ps2_receiver_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clock_in,
    input  logic       ps2_data_in,
    output logic [7:0] ps2_out,
    output logic       ps2_key_pressed,
    output logic       parity_error,
    output logic       frame_error,
    output logic [1:0] dbg_state
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic w_clk_level;
    logic w_clk_fall;
    logic w_data;
    logic w_data_fall;
    logic w_unused;

    ps2_state_t r_state;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic          r_parity;
    logic [TW-1:0] r_timeout;
`ifdef PS2_BREAK_FILTER_EN
    logic          r_break_pending;
`endif

    ps2_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (
        .clock   (clock),
        .reset   (reset),
        .i_pin   (ps2_clock_in),
        .o_level (w_clk_level),
        .o_fall  (w_clk_fall)
    );

    ps2_sync #(.STAGES(SYNC_STAGES)) u_sync_data (
        .clock   (clock),
        .reset   (reset),
        .i_pin   (ps2_data_in),
        .o_level (w_data),
        .o_fall  (w_data_fall)
    );

    assign w_unused  = w_clk_level ^ w_data_fall;
    assign dbg_state = r_state;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_bitcnt        <= '0;
            r_shift         <= '0;
            r_parity        <= 1'b0;
            r_timeout       <= '0;
            ps2_out         <= 8'h00;
            ps2_key_pressed <= 1'b0;
            parity_error    <= 1'b0;
            frame_error     <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
            r_break_pending <= 1'b0;
`endif
        end else begin
            ps2_key_pressed <= 1'b0;
            parity_error    <= 1'b0;
            frame_error     <= 1'b0;

            // A fall always wins over the timeout terminal count.
            if (w_clk_fall) begin
                r_timeout <= '0;
                case (r_state)
                    ST_IDLE: begin
                        if (!w_data) begin
                            r_state  <= ST_DATA;
                            r_bitcnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        r_shift[r_bitcnt] <= w_data;
                        if (r_bitcnt == 3'd7) r_state <= ST_PARITY;
                        else                  r_bitcnt <= r_bitcnt + 3'd1;
                    end
                    ST_PARITY: begin
                        r_parity <= w_data;
                        r_state  <= ST_STOP;
                    end
                    ST_STOP: begin
                        r_state <= ST_IDLE;
                        if (!w_data) begin
                            frame_error <= 1'b1;
                        end else if (!odd_parity_ok(r_shift, r_parity)) begin
                            parity_error <= 1'b1;
                        end else begin
`ifdef PS2_BREAK_FILTER_EN
                            if (r_shift == PS2_EXT_CODE) begin
                                ps2_out         <= r_shift;
                                ps2_key_pressed <= 1'b1;
                            end else if (r_shift == PS2_BREAK_CODE) begin
                                r_break_pending <= 1'b1;
                            end else if (r_break_pending) begin
                                r_break_pending <= 1'b0;
                            end else begin
                                ps2_out         <= r_shift;
                                ps2_key_pressed <= 1'b1;
                            end
`else
                            ps2_out         <= r_shift;
                            ps2_key_pressed <= 1'b1;
`endif
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end else if (r_state == ST_IDLE) begin
                r_timeout <= '0;
            end else if (r_timeout == TW'(TIMEOUT_CYCLES)) begin
                r_state     <= ST_IDLE;
                r_timeout   <= '0;
                frame_error <= 1'b1;
            end else begin
                r_timeout <= r_timeout + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: table of whole frames plus timeout and mid-frame reset sequences.
module tb_ps2_receiver;

    localparam int SYNC       = 2;
    localparam int TIMEOUT    = 400;
    localparam int HALF       = 40;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] ps2_out;
    logic       key_pressed;
    logic       parity_error;
    logic       frame_error;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;
    int k_cnt = 0;
    int p_cnt = 0;
    int f_cnt = 0;
    logic       prev_strobe = 1'b0;
    logic [7:0] exp_q[$];

    always #5 clock = ~clock;

    ps2_receiver #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clock           (clock),
        .reset           (reset),
        .ps2_clock_in    (ps2_clk),
        .ps2_data_in     (ps2_dat),
        .ps2_out         (ps2_out),
        .ps2_key_pressed (key_pressed),
        .parity_error    (parity_error),
        .frame_error     (frame_error),
        .dbg_state       (dbg_state)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every key strobe must match the next expected byte; strobes exclusive and isolated.
    always @(negedge clock) begin
        if (key_pressed) begin
            k_cnt++;
            if (exp_q.size() == 0) check("unexpected_key", int'(ps2_out), -1);
            else check("key_byte", int'(ps2_out), int'(exp_q.pop_front()));
        end
        if (parity_error) p_cnt++;
        if (frame_error)  f_cnt++;
        if (key_pressed || parity_error || frame_error) begin
            check("strobe_exclusive", int'(key_pressed) + int'(parity_error) + int'(frame_error), 1);
            check("strobe_isolated", int'(prev_strobe), 0);
        end
        prev_strobe = key_pressed | parity_error | frame_error;
    end

    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = bits[i];
            repeat (HALF / 2) @(negedge clock);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clock);
            ps2_clk = 1'b1;
            repeat (HALF / 2) @(negedge clock);
        end
        ps2_dat = 1'b1;
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] d, input bit flip, input bit stop);
        logic par;
        par = ~(^d) ^ flip;
        return {stop, par, d, 1'b0};
    endfunction

    typedef struct {
        logic [7:0] d;
        bit         flip;
        bit         stop;
        int         k;
        int         p;
        int         f;
        logic [7:0] out;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int k0, p0, f0;
        vecs[0]  = '{8'h1C, 1'b0, 1'b1, 1, 0, 0, 8'h1C};
        vecs[1]  = '{8'h1C, 1'b1, 1'b1, 0, 1, 0, 8'h1C};
        vecs[2]  = '{8'h5A, 1'b0, 1'b0, 0, 0, 1, 8'h1C};
        vecs[3]  = '{8'h29, 1'b0, 1'b1, 1, 0, 0, 8'h29};
        vecs[4]  = '{8'h5A, 1'b1, 1'b0, 0, 0, 1, 8'h29};
        vecs[5]  = '{8'h00, 1'b0, 1'b1, 1, 0, 0, 8'h00};
        vecs[6]  = '{8'hFF, 1'b0, 1'b1, 1, 0, 0, 8'hFF};
`ifdef PS2_BREAK_FILTER_EN
        vecs[7]  = '{8'hF0, 1'b0, 1'b1, 0, 0, 0, 8'hFF};
        vecs[8]  = '{8'h1C, 1'b0, 1'b1, 0, 0, 0, 8'hFF};
`else
        vecs[7]  = '{8'hF0, 1'b0, 1'b1, 1, 0, 0, 8'hF0};
        vecs[8]  = '{8'h1C, 1'b0, 1'b1, 1, 0, 0, 8'h1C};
`endif
        vecs[9]  = '{8'hE0, 1'b0, 1'b1, 1, 0, 0, 8'hE0};
        vecs[10] = '{8'h45, 1'b0, 1'b1, 1, 0, 0, 8'h45};

        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset_out", int'(ps2_out), 8'h00);
        check("reset_strobes", int'({key_pressed, parity_error, frame_error}), 0);
        check("reset_state", int'(dbg_state), 0);

        foreach (vecs[i]) begin
            k0 = k_cnt; p0 = p_cnt; f0 = f_cnt;
            if (vecs[i].k != 0) exp_q.push_back(vecs[i].d);
            send_bits(make_frame(vecs[i].d, vecs[i].flip, vecs[i].stop), 11);
            repeat (10) @(negedge clock);
            check($sformatf("v%0d_key", i), k_cnt - k0, vecs[i].k);
            check($sformatf("v%0d_par", i), p_cnt - p0, vecs[i].p);
            check($sformatf("v%0d_frm", i), f_cnt - f0, vecs[i].f);
            check($sformatf("v%0d_out", i), int'(ps2_out), int'(vecs[i].out));
            check($sformatf("v%0d_idle", i), int'(dbg_state), 0);
        end

        // Partial frame then silence: the timeout drops it with a frame error.
        k0 = k_cnt; f0 = f_cnt;
        send_bits(make_frame(8'h33, 1'b0, 1'b1), 4);
        check("partial_state", int'(dbg_state), 1);
        repeat (TIMEOUT + 60) @(negedge clock);
        check("timeout_frm", f_cnt - f0, 1);
        check("timeout_key", k_cnt - k0, 0);
        check("timeout_state", int'(dbg_state), 0);
        check("timeout_out", int'(ps2_out), 8'h45);
        exp_q.push_back(8'h45);
        send_bits(make_frame(8'h45, 1'b0, 1'b1), 11);
        repeat (10) @(negedge clock);
        check("after_timeout_key", k_cnt - k0, 1);
        check("after_timeout_out", int'(ps2_out), 8'h45);

        // One-cycle reset in the middle of a frame discards it silently.
        k0 = k_cnt; p0 = p_cnt; f0 = f_cnt;
        send_bits(make_frame(8'h77, 1'b0, 1'b1), 4);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midreset_out", int'(ps2_out), 8'h00);
        check("midreset_state", int'(dbg_state), 0);
        repeat (TIMEOUT + 20) @(negedge clock);
        check("midreset_strobes", (k_cnt - k0) + (p_cnt - p0) + (f_cnt - f0), 0);
        exp_q.push_back(8'h16);
        send_bits(make_frame(8'h16, 1'b0, 1'b1), 11);
        repeat (10) @(negedge clock);
        check("after_reset_key", k_cnt - k0, 1);
        check("after_reset_out", int'(ps2_out), 8'h16);

        check("exp_q_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
